and_64_reg: RTL and testbench
=============================

Name: and_64_reg

Overview:
- Registered 64-bit bitwise-AND unit for the Y86-64 ALU datapath (the andq operation).
- Takes two 64-bit two's-complement operands and returns their bitwise AND.
- Also produces Y86-64 condition-code flags (ZF, SF, OF) for the result.
- Output is registered with one-cycle latency and a valid strobe, so it drops into the pipelined execute stage.

Parameters:
- WIDTH, 64, operand/result width in bits. Only 64 is required to be verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on a/b are valid this cycle.
- a  input  64  operand A, signed two's complement.
- b  input  64  operand B, signed two's complement.
- ans  output  64  registered result, a & b.
- zf  output  1  zero flag: 1 when ans == 0.
- sf  output  1  sign flag: equals ans[63].
- of  output  1  overflow flag: always 0 for AND.
- out_valid  output  1  ans/zf/sf/of hold a freshly computed result this cycle.

Behaviour:
- Reset:
  - While rst_n = 0, immediately and independently of clk: ans = 0, zf = 0, sf = 0, of = 0, out_valid = 0.
  - After rst_n deasserts, the first capture happens on the next rising clk with in_valid = 1.
- Compute:
  - Purely bitwise: ans[i] = a[i] & b[i] for i = 0..63.
  - No carry, no sign extension, no saturation.
  - Signedness affects only the interpretation of sf.
- Latency:
  - Operands sampled at rising edge N with in_valid = 1 appear on ans and flags after edge N, valid throughout cycle N+1.
  - out_valid is 1 for exactly that cycle.
- Throughput: one operation per cycle. Back-to-back in_valid pulses produce back-to-back results, with no bubbles and no stall input.
- Hold: on an edge with in_valid = 0, ans/zf/sf/of keep their previous values and out_valid goes to 0.
- Flags:
  - zf, sf and of are registered together with ans in the same edge, so they are always consistent with the current ans.
  - of is constant 0 after reset.
- Reset mid-operation: asserting rst_n low at any time clears all outputs asynchronously and discards the in-flight result. No result appears after release unless new in_valid is applied.
- No X propagation from unused inputs: when in_valid = 0, a/b changes must not affect the outputs.

Test Plan:
- Reset: hold rst_n = 0 with arbitrary a/b and toggling clk -> ans = 0, flags = 0, out_valid = 0. Release, apply a = 20, b = 50, in_valid = 1 -> next cycle ans = 16, zf = 0, sf = 0, of = 0, out_valid = 1.
- Signed mix, back to back, in_valid held high, one result per cycle in order:
  - a = -20, b = 50 -> ans = 32
  - a = 20, b = -50 -> ans = 4
  - a = -20, b = -50 -> ans = -52 (0xFFFFFFFFFFFFFFCC), sf = 1, zf = 0
- Zero result: a = 0xAAAAAAAAAAAAAAAA, b = 0x5555555555555555 -> ans = 0, zf = 1, sf = 0. Then a = b = 0xFFFFFFFFFFFFFFFF -> ans = all ones, sf = 1, zf = 0.
- Large values:
  - a = 100000000000000000, b = 110101010101010101 -> ans equals the bench model a & b.
  - Repeat with all four sign combinations of ±a, ±b; ans must match the model every time and sf must equal ans[63].
- Hold / valid gating: after a result, drop in_valid and change a/b randomly for 5 cycles -> ans and flags unchanged, out_valid = 0.
- Async reset mid-stream: assert rst_n low between clock edges while out_valid = 1 -> outputs clear immediately, without waiting for clk. After release with in_valid = 0, out_valid stays 0.

Source files
------------

// File: rtl/and_64_reg.sv
// Registered bitwise AND (Y86-64 andq) with ZF/SF/OF flags; one-cycle latency.
// One operation per cycle, no stall input; flags and result update only on in_valid.
module and_64_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ans,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] r_ans;
    logic             r_zf;
    logic             r_sf;
    logic             r_vld;

    assign w_and = a & b;

    // Flags are captured on the same edge as the result so they never disagree with ans.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ans <= '0;
            r_zf  <= 1'b0;
            r_sf  <= 1'b0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_ans <= w_and;
                r_zf  <= (w_and == '0);
                r_sf  <= w_and[WIDTH-1];
            end
        end
    end

    assign ans       = r_ans;
    assign zf        = r_zf;
    assign sf        = r_sf;
    assign of        = 1'b0;
    assign out_valid = r_vld;

endmodule

// File: tb/tb_and_64_reg.sv
// Directed self-checking bench for and_64_reg.
module tb_and_64_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] ans;
    logic        zf;
    logic        sf;
    logic        of;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    and_64_reg #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .ans       (ans),
        .zf        (zf),
        .sf        (sf),
        .of        (of),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic [63:0] e_ans,
                              input logic e_zf, input logic e_sf, input logic e_vld);
        chk({tag, ".ans"}, ans, e_ans);
        chk({tag, ".zf"}, {63'd0, zf}, {63'd0, e_zf});
        chk({tag, ".sf"}, {63'd0, sf}, {63'd0, e_sf});
        chk({tag, ".of"}, {63'd0, of}, 64'd0);
        chk({tag, ".vld"}, {63'd0, out_valid}, {63'd0, e_vld});
    endtask

    // Drive one valid operation right after an edge, then sample 1ns after the capturing edge.
    task automatic op(input logic [63:0] va, input logic [63:0] vb);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] big_a;
    logic [63:0] big_b;
    logic [63:0] model;
    logic [63:0] last;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 64'hDEAD_BEEF_0123_4567;
        b        = 64'hFFFF_0000_FFFF_0000;

        // Reset held across several clock edges with live inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            expect_out("reset", 64'd0, 1'b0, 1'b0, 1'b0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        a        = 64'd20;
        b        = 64'd50;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        expect_out("first", 64'd16, 1'b0, 1'b0, 1'b1);

        // Back-to-back signed mix.
        op(-64'd20, 64'd50);
        expect_out("neg_a", 64'd32, 1'b0, 1'b0, 1'b1);
        op(64'd20, -64'd50);
        expect_out("neg_b", 64'd4, 1'b0, 1'b0, 1'b1);
        op(-64'd20, -64'd50);
        expect_out("neg_ab", 64'hFFFF_FFFF_FFFF_FFCC, 1'b0, 1'b1, 1'b1);

        op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
        expect_out("zero", 64'd0, 1'b1, 1'b0, 1'b1);
        op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_out("ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);

        // Large operands in all four sign combinations.
        for (int s = 0; s < 4; s++) begin
            big_a = s[0] ? -64'd100000000000000000 : 64'd100000000000000000;
            big_b = s[1] ? -64'd110101010101010101 : 64'd110101010101010101;
            model = big_a & big_b;
            op(big_a, big_b);
            expect_out($sformatf("large%0d", s), model, model == 64'd0, model[63], 1'b1);
        end
        last = model;

        // Hold: in_valid low, operands churn, outputs frozen.
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(posedge clk);
            #1;
            expect_out($sformatf("hold%0d", i), last, last == 64'd0, last[63], 1'b0);
        end

        // Async reset between edges while a result is valid.
        op(64'h8000_0000_0000_00F0, 64'hF000_0000_0000_0030);
        expect_out("pre_rst", 64'h8000_0000_0000_0030, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        expect_out("async_rst", 64'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(posedge clk);
            #1;
            expect_out($sformatf("post_rst%0d", i), 64'd0, 1'b0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
